// File: rtl/hilbert_pkg.sv
//------------------------------------------------------------------------------
// Module  : hilbert_pkg
// Brief   : Shared types, coefficient ROM and rounding/saturation helpers for
//           the Hilbert FIR.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package hilbert_pkg;

    localparam int CW_DEF = 16;
    localparam int QC_DEF = 15;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MAC   = 2'd1,
        S_ROUND = 2'd2
    } state_t;

    // Number of nonzero antisymmetric tap pairs for a type-III length.
    function automatic int nmac(input int ntaps);
        return (ntaps + 1) / 4;
    endfunction

    // Hamming-windowed ideal Hilbert taps, Q15, for NTAPS=31 (k = 2j+1).
    function automatic int coef(input int j);
        case (j)
            0:       return 20651;
            1:       return 6343;
            2:       return 3213;
            3:       return 1753;
            4:       return 922;
            5:       return 440;
            6:       return 192;
            7:       return 111;
            default: return 0;
        endcase
    endfunction

    // Arithmetic shift right with half-up rounding; negative sh shifts left.
    function automatic longint round_shr(input longint v, input int sh);
        if (sh <= 0) return v <<< (-sh);
        return (v + (longint'(1) <<< (sh - 1))) >>> sh;
    endfunction

    function automatic longint sat_val(input longint v, input int m);
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (m - 1)) - 1;
        lo = -(longint'(1) <<< (m - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/hilbert_mac.sv
//------------------------------------------------------------------------------
// Module  : hilbert_mac
// Brief   : Hilbert FIR datapath: pre-subtract, pipelined multiply, accumulate,
//           round and saturate. Optional macro: HILBERT_FIR_SATFLAG_EN (ovf_o).
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module hilbert_mac
    import hilbert_pkg::*;
#(
    parameter int N  = 16,
    parameter int QN = 10,
    parameter int M  = 16,
    parameter int QM = 10,
    parameter int CW = CW_DEF,
    parameter int QC = QC_DEF,
    parameter int NM = 8,
    parameter int JW = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                clr_i,
    input  logic                mul_en_i,
    input  logic                rnd_i,
    input  logic [JW-1:0]       j_i,
    input  logic signed [N-1:0] pos_i,
    input  logic signed [N-1:0] neg_i,
    input  logic signed [N-1:0] ctr_i,
    output logic signed [M-1:0] yi_o,
    output logic signed [M-1:0] yq_o
`ifdef HILBERT_FIR_SATFLAG_EN
    ,
    output logic                ovf_o
`endif
);

    localparam int DW = N + 1;
    localparam int PW = DW + CW;
    localparam int AW = PW + $clog2(NM);
    localparam int SH = QN + QC - QM;

    logic signed [DW-1:0] w_diff;
    logic signed [CW-1:0] w_coef;
    logic signed [PW-1:0] w_prod;
    logic signed [PW-1:0] prod_q;
    logic                 pv_q;
    logic signed [AW-1:0] acc_q;
    logic signed [M-1:0]  yi_q, yq_q, w_yi, w_yq;
    longint               w_q_full, w_i_full;

    assign w_diff = DW'(pos_i) - DW'(neg_i);
    assign w_coef = CW'(coef(int'(j_i)));
    assign w_prod = PW'(w_diff) * PW'(w_coef);

    always_comb begin
        w_q_full = round_shr(longint'(acc_q), SH);
        w_i_full = round_shr(longint'(ctr_i), QN - QM);
        w_yq     = M'(sat_val(w_q_full, M));
        w_yi     = M'(sat_val(w_i_full, M));
    end

    // The product is registered; pv_q marks a product awaiting accumulation.
    always_ff @(posedge clock) begin
        if (reset) begin
            prod_q <= '0;
            pv_q   <= 1'b0;
            acc_q  <= '0;
            yi_q   <= '0;
            yq_q   <= '0;
        end else begin
            pv_q <= mul_en_i;
            if (mul_en_i) prod_q <= w_prod;
            if (clr_i)     acc_q <= '0;
            else if (pv_q) acc_q <= acc_q + AW'(prod_q);
            if (rnd_i) begin
                yi_q <= w_yi;
                yq_q <= w_yq;
            end
        end
    end

    assign yi_o = yi_q;
    assign yq_o = yq_q;

`ifdef HILBERT_FIR_SATFLAG_EN
    logic ovf_q;
    always_ff @(posedge clock) begin
        if (reset)      ovf_q <= 1'b0;
        else if (rnd_i) ovf_q <= (w_q_full != longint'(w_yq)) || (w_i_full != longint'(w_yi));
    end
    assign ovf_o = ovf_q;
`endif

endmodule

`default_nettype wire

// File: rtl/hilbert_fir.sv
//------------------------------------------------------------------------------
// Module  : hilbert_fir
// Brief   : Sequential type-III Hilbert FIR producing an I/Q pair per sample.
//           Optional macro: HILBERT_FIR_SATFLAG_EN adds the ovf output.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module hilbert_fir
    import hilbert_pkg::*;
#(
    parameter int NTAPS = 31,
    parameter int N     = 16,
    parameter int QN    = 10,
    parameter int M     = 16,
    parameter int QM    = 10,
    parameter int CW    = CW_DEF,
    parameter int QC    = QC_DEF
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic signed [N-1:0] X,
    output logic                ready,
    output logic signed [M-1:0] Yi,
    output logic signed [M-1:0] Yq
`ifdef HILBERT_FIR_SATFLAG_EN
    ,
    output logic                ovf
`endif
);

    localparam int C  = (NTAPS - 1) / 2;
    localparam int NM = nmac(NTAPS);
    localparam int JW = $clog2(NM + 1);

    state_t              state_q, state_d;
    logic [JW-1:0]       j_q, j_d;
    logic                ready_q, ready_d;
    logic signed [N-1:0] d_q [NTAPS];
    logic                w_accept, w_mul_en, w_rnd;
    logic signed [N-1:0] w_pos, w_neg;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            j_q     <= '0;
            ready_q <= 1'b0;
            for (int i = 0; i < NTAPS; i++) d_q[i] <= '0;
        end else begin
            state_q <= state_d;
            j_q     <= j_d;
            ready_q <= ready_d;
            if (w_accept) begin
                d_q[0] <= X;
                for (int i = 1; i < NTAPS; i++) d_q[i] <= d_q[i-1];
            end
        end
    end

    // MAC runs one extra step (j == NM) to drain the registered product.
    always_comb begin
        state_d  = state_q;
        j_d      = j_q;
        ready_d  = ready_q;
        w_accept = 1'b0;
        w_mul_en = 1'b0;
        w_rnd    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    ready_d  = 1'b0;
                    j_d      = '0;
                    state_d  = S_MAC;
                end
            end
            S_MAC: begin
                w_mul_en = (j_q < JW'(NM));
                j_d      = j_q + JW'(1);
                if (j_q == JW'(NM)) state_d = S_ROUND;
            end
            S_ROUND: begin
                w_rnd   = 1'b1;
                ready_d = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        w_pos = '0;
        w_neg = '0;
        for (int jj = 0; jj < NM; jj++) begin
            if (j_q == JW'(jj)) begin
                w_pos = d_q[C - 2*jj - 1];
                w_neg = d_q[C + 2*jj + 1];
            end
        end
    end

    hilbert_mac #(
        .N  (N),
        .QN (QN),
        .M  (M),
        .QM (QM),
        .CW (CW),
        .QC (QC),
        .NM (NM),
        .JW (JW)
    ) u_mac (
        .clock    (clock),
        .reset    (reset),
        .clr_i    (w_accept),
        .mul_en_i (w_mul_en),
        .rnd_i    (w_rnd),
        .j_i      (j_q),
        .pos_i    (w_pos),
        .neg_i    (w_neg),
        .ctr_i    (d_q[C]),
        .yi_o     (Yi),
        .yq_o     (Yq)
`ifdef HILBERT_FIR_SATFLAG_EN
        ,
        .ovf_o    (ovf)
`endif
    );

    assign ready = ready_q;

endmodule

`default_nettype wire

// File: tb/tb_hilbert_fir.sv
//------------------------------------------------------------------------------
// Module  : tb_hilbert_fir
// Brief   : Directed self-checking bench for hilbert_fir (impulse, DC,
//           saturation, handshake, reset abort, back-to-back).
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_hilbert_fir;

    logic               clock = 1'b0;
    logic               reset;
    logic               start;
    logic signed [15:0] X;
    logic               ready;
    logic signed [15:0] Yi, Yq;
`ifdef HILBERT_FIR_SATFLAG_EN
    logic               ovf;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int lat;

    // Q10 impulse response: round(coef/32) at even offsets, antisymmetric.
    int c_imp_yq [31] = '{3, 0, 6, 0, 14, 0, 29, 0, 55, 0, 100, 0, 198, 0, 645, 0,
                          -645, 0, -198, 0, -100, 0, -55, 0, -29, 0, -14, 0, -6, 0, -3};

    always #5 clock = ~clock;

    hilbert_fir dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .X     (X),
        .ready (ready),
        .Yi    (Yi),
        .Yq    (Yq)
`ifdef HILBERT_FIR_SATFLAG_EN
        ,
        .ovf   (ovf)
`endif
    );

    task automatic check_value(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        start = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1 reset = 1'b0;
    endtask

    // Waits up to 20 edges after the accepting edge; lat=0 means timeout.
    task automatic wait_ready(input int first, output int l);
        l = 0;
        for (int c = first; c <= 20 && l == 0; c++) begin
            @(posedge clock);
            #1;
            if (ready) l = c;
        end
    endtask

    task automatic conv(input logic signed [15:0] x, output int l);
        @(negedge clock);
        start = 1'b1;
        X     = x;
        @(posedge clock);
        #1 start = 1'b0;
        wait_ready(1, l);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        X     = '0;
        do_reset();
        check_value("rst_ready", ready, 0);
        check_value("rst_yi", Yi, 0);
        check_value("rst_yq", Yq, 0);
`ifdef HILBERT_FIR_SATFLAG_EN
        check_value("rst_ovf", ovf, 0);
`endif

        // Impulse conversion 0, with a second start pulse 3 edges later.
        @(negedge clock);
        start = 1'b1;
        X     = 16'sd1024;
        @(posedge clock);
        #1 start = 1'b0;
        X = 16'sd777;
        check_value("hs_ready_cleared", ready, 0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        wait_ready(4, lat);
        check_value("hs_latency", lat, 10);
        repeat (3) @(posedge clock);
        #1 check_value("hs_ready_held", ready, 1);
        check_value("imp_yq[0]", Yq, c_imp_yq[0]);
        check_value("imp_yi[0]", Yi, 0);

        for (int n = 1; n < 31; n++) begin
            conv(16'sd0, lat);
            check_value($sformatf("imp_yq[%0d]", n), Yq, c_imp_yq[n]);
            check_value($sformatf("imp_yi[%0d]", n), Yi, (n == 15) ? 1024 : 0);
        end

        for (int n = 0; n < 40; n++) begin
            conv(16'sd512, lat);
            if (n >= 30) begin
                check_value($sformatf("dc_yq[%0d]", n), Yq, 0);
                check_value($sformatf("dc_yi[%0d]", n), Yi, 512);
            end
        end

        // Abort on MAC cycle 4; the next sample must see an empty delay line.
        @(negedge clock);
        start = 1'b1;
        X     = 16'sd5000;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        check_value("abort_ready", ready, 0);
        check_value("abort_yi", Yi, 0);
        check_value("abort_yq", Yq, 0);
        repeat (12) @(posedge clock);
        #1 check_value("abort_no_result", ready, 0);
        conv(16'sd1024, lat);
        check_value("abort_lat", lat, 10);
        check_value("abort_imp_yq", Yq, c_imp_yq[0]);
        check_value("abort_imp_yi", Yi, 0);

        // Back-to-back: start held over the ROUND edge and the following edge.
        @(negedge clock);
        start = 1'b1;
        X     = 16'sd0;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (9) @(posedge clock);
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1 check_value("b2b_ready_rise", ready, 1);
        @(posedge clock);
        #1 start = 1'b0;
        check_value("b2b_second_accepted", ready, 0);
        wait_ready(1, lat);
        check_value("b2b_latency", lat, 10);
        check_value("b2b_yq", Yq, c_imp_yq[2]);

        // Full-scale period-4 pattern: steady state stays just inside range.
        do_reset();
        for (int n = 0; n < 40; n++) begin
            conv(((n % 4) < 2) ? 16'sd32767 : -16'sd32768, lat);
            if (n >= 30) begin
                check_value($sformatf("pat_yq[%0d]", n), Yq, ((n % 4) >= 2) ? 32662 : -32662);
`ifdef HILBERT_FIR_SATFLAG_EN
                check_value($sformatf("pat_ovf[%0d]", n), ovf, 0);
`endif
            end
        end

        // Full-scale step into an empty line: all taps align, Yq clamps.
        for (int s = 0; s < 2; s++) begin
            do_reset();
            for (int n = 0; n < 16; n++) conv((s == 0) ? 16'sd32767 : -16'sd32768, lat);
            check_value($sformatf("step_yq[%0d]", s), Yq, (s == 0) ? 32767 : -32768);
            check_value($sformatf("step_yi[%0d]", s), Yi, (s == 0) ? 32767 : -32768);
`ifdef HILBERT_FIR_SATFLAG_EN
            check_value($sformatf("step_ovf[%0d]", s), ovf, 1);
`endif
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
